// File: rtl/audio_interp.sv
// Buffers low-rate Q1.13 audio in a small FIFO and linearly interpolates between
// consecutive samples, producing one step-free output sample per clock.
module audio_interp #(
  parameter int INTERP_LOG2     = 10,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [13:0]                s_data,
  input  logic                       clear_underrun,
  output logic [13:0]                audio_q13,
  output logic                       underrun,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int PW    = 15 + INTERP_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, RUN, STARVED} state_t;

  logic [13:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q, count_d;
  state_t                     state_q, state_d;
  logic [INTERP_LOG2-1:0]     phase_q, phase_d;
  logic signed [13:0]         x0_q, x0_d, x1_q, x1_d;
  logic                       underrun_q, underrun_d;
  logic [13:0]                y_q;

  logic                       push, pop, empty, boundary;
  logic signed [13:0]         head;
  logic signed [14:0]         diff;
  logic signed [PW-1:0]       prod;
  logic [13:0]                y;

  assign s_ready    = (count_q != CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = s_valid && s_ready;
  assign boundary   = (phase_q == '1);
  assign head       = mem[rd_ptr_q];
  assign fifo_level = count_q;
  assign underrun   = underrun_q;
  assign audio_q13  = y_q;

  // Sample storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    underrun_d = underrun_q;
    pop        = 1'b0;
    if (clear_underrun) underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        // Prefill of two samples; first segment ramps up from silence.
        if (count_q >= CW'(2)) begin
          pop     = 1'b1;
          x0_d    = '0;
          x1_d    = head;
          state_d = RUN;
        end
      end
      RUN: begin
        phase_d = phase_q + INTERP_LOG2'(1);
        if (boundary) begin
          x0_d = x1_q;
          if (!empty) begin
            pop  = 1'b1;
            x1_d = head;
          end else begin
            underrun_d = 1'b1;
            state_d    = STARVED;
          end
        end
      end
      STARVED: begin
        phase_d = phase_q + INTERP_LOG2'(1);
        if (boundary && !empty) begin
          pop     = 1'b1;
          x0_d    = x1_q;
          x1_d    = head;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Floor-rounded interpolation; the result stays between x0 and x1, so the
  // 14-bit wrap-around sum is exact.
  always_comb begin
    diff = 15'(x1_q) - 15'(x0_q);
    prod = PW'(diff) * PW'($signed({1'b0, phase_q}));
    y    = x0_q + 14'(prod >>> INTERP_LOG2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      phase_q    <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      underrun_q <= 1'b0;
      y_q        <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
      count_q    <= count_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      underrun_q <= underrun_d;
      y_q        <= y;
    end
  end

endmodule
